// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard detection for a 5-stage MIPS-style core with an iterative
// mult/div unit.
//
// It detects load-use, branch-on-load and mult/div occupancy hazards in ID,
// and it lets memory waits in MEM freeze the whole front of the pipe. It also
// sequences the mult/div unit: a start pulse, a busy window and a one-cycle
// HI/LO write enable.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   rs_addrD, rt_addrD, uses_rtD    ID source registers
//   branchD, pc_srcD                ID branch/jump and its taken flag
//   md_startD, md_is_divD, mfhiloD  ID mult/div launch and HI/LO read
//   reg_writeE, mem_to_regE, write_reg_addrE   EX destination info
//   reg_writeM, mem_to_regM, write_reg_addrM   MEM destination info
//   mem_reqM, mem_readyM            MEM data-memory handshake
//   stallF/D/E/M, flushD/E          pipeline register control (combinational)
//   md_start, md_busy, md_hilo_we   mult/div unit control
// -----------------------------------------------------------------------------
module hazard_controller #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs_addrD,
   input  logic [4:0] rt_addrD,
   input  logic       uses_rtD,
   input  logic       branchD,
   input  logic       pc_srcD,
   input  logic       md_startD,
   input  logic       md_is_divD,
   input  logic       mfhiloD,
   input  logic       reg_writeE,
   input  logic       mem_to_regE,
   input  logic [4:0] write_reg_addrE,
   input  logic       reg_writeM,
   input  logic       mem_to_regM,
   input  logic [4:0] write_reg_addrM,
   input  logic       mem_reqM,
   input  logic       mem_readyM,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       flushD,
   output logic       flushE,
   output logic       md_start,
   output logic       md_busy,
   output logic       md_hilo_we
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_t;

   // The counter is preloaded with latency-2: one cycle is spent in the start
   // edge and one in DONE, so BUSY lasts exactly latency-1 cycles.
   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 32'd2);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 32'd2);

   md_state_t  state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       md_start_q, md_start_d;
   logic       md_hilo_we_q, md_hilo_we_d;

   logic       load_use_haz;
   logic       branch_haz;
   logic       md_haz;
   logic       mem_wait;

   assign md_busy    = (state_q != S_IDLE);
   assign md_start   = md_start_q;
   assign md_hilo_we = md_hilo_we_q;

   // Hazard detection. $0 is hard-wired, so it never creates a dependency.
   always_comb begin
      load_use_haz = 1'b0;
      branch_haz   = 1'b0;
      md_haz       = 1'b0;
      mem_wait     = 1'b0;
      if (mem_to_regE && reg_writeE && (write_reg_addrE != 5'd0)) begin
         load_use_haz = (write_reg_addrE == rs_addrD) ||
                        (uses_rtD && (write_reg_addrE == rt_addrD));
      end else begin
         load_use_haz = 1'b0;
      end
      // Only a load still in MEM matters for a branch; EX ALU results forward.
      if (branchD && mem_to_regM && reg_writeM && (write_reg_addrM != 5'd0)) begin
         branch_haz = (write_reg_addrM == rs_addrD) ||
                      (write_reg_addrM == rt_addrD);
      end else begin
         branch_haz = 1'b0;
      end
      md_haz   = (md_startD || mfhiloD) && md_busy;
      mem_wait = mem_reqM && !mem_readyM;
   end

   // Stall/flush generation; a memory wait overrides every other hazard.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushE = 1'b0;
      flushD = 1'b0;
      if (mem_wait) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else if (load_use_haz || branch_haz || md_haz) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end else begin
         stallF = 1'b0;
      end
      flushD = pc_srcD && !stallD;
   end

   // Mult/div sequencer next state; keeps running through memory waits.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      md_start_d   = 1'b0;
      md_hilo_we_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md_startD && !stallD) begin
               state_d    = S_BUSY;
               md_start_d = 1'b1;
               cnt_d      = md_is_divD ? DIV_LOAD : MULT_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (cnt_q == 6'd0) begin
               state_d      = S_DONE;
               md_hilo_we_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // Sequencer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 6'd0;
         md_start_q   <= 1'b0;
         md_hilo_we_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         md_start_q   <= md_start_d;
         md_hilo_we_q <= md_hilo_we_d;
      end
   end

endmodule
